// File: rtl/bist_pkg.sv
// Shared definitions for the LFSR/MISR self-test wrapper.
//   state_t       : sequencer states (IDLE, RUN, DONE)
//   SIG_W/LFSR_W  : signature and pattern-generator widths
//   PAT_W         : width of the pattern applied to the circuit under test
//   LFSR_TAPS     : x^16+x^14+x^13+x^11+1 as a mask over l[15:0]
//   DEF_MISR_POLY : default signature polynomial (bit i = x^i)
package bist_pkg;
  localparam int SIG_W  = 16;
  localparam int LFSR_W = 16;
  localparam int PAT_W  = 6;

  // Feedback taken from l[15], l[13], l[12], l[10].
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [SIG_W-1:0]  DEF_MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fibonacci step: shift left, feedback parity enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/bist_misr.sv
// Serial-input signature register (single-input MISR).
//   clk, rst : clock, synchronous active-high reset (clears signature)
//   clr      : synchronous clear, used at the start of each run
//   en       : shift/compact enable
//   din      : serial response bit folded into bit 0
//   sig      : current signature
module bist_misr
  import bist_pkg::*;
#(
  parameter int              W    = SIG_W,
  parameter logic [W-1:0]    POLY = W'(DEF_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      sig <= '0;
    else if (en)
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ {{(W-1){1'b0}}, din};
  end

endmodule

// File: rtl/lfsr_bist_wrapper.sv
// Self-test wrapper for the six-input layered example circuits.
// An LFSR drives {a,b,c,d,e,g} = pat_o, the circuit's output f returns on
// resp_i and is compacted by a MISR. One start pulse applies exactly
// N_PATTERNS vectors, then the block parks in DONE with the signature held.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request, honoured in IDLE or DONE, ignored in RUN
//   resp_i     : circuit output for the pattern on pat_o this cycle
//   pat_o      : lfsr[5:0] while running, zero otherwise
//   busy, done : RUN / DONE state flags (registered, mutually exclusive)
//   signature  : MISR contents
//   pat_count  : vectors applied in the current or last run (saturates)
// Optional macro BIST_GOLDEN_CMP_EN adds output pass = DONE && signature==GOLDEN_SIG.
module lfsr_bist_wrapper
  import bist_pkg::*;
#(
  parameter int                 N_PATTERNS = 64,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1,
  parameter logic [SIG_W-1:0]   MISR_POLY  = DEF_MISR_POLY,
  parameter logic [SIG_W-1:0]   GOLDEN_SIG = 16'h0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              resp_i,
  output logic [PAT_W-1:0]                  pat_o,
  output logic                              busy,
  output logic                              done,
  output logic [SIG_W-1:0]                  signature,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pat_count
`ifdef BIST_GOLDEN_CMP_EN
  ,
  output logic                              pass
`endif
);

  localparam int            CW   = $clog2(N_PATTERNS+1);
  localparam logic [CW-1:0] LAST = CW'(N_PATTERNS-1);
  localparam logic [CW-1:0] FULL = CW'(N_PATTERNS);

  state_t             state;
  logic [LFSR_W-1:0]  lfsr;
  logic               launch;
  logic               running;

  assign running = (state == RUN);
  assign launch  = start && !running;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      pat_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            lfsr      <= LFSR_SEED;
            pat_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          lfsr <= lfsr_step(lfsr);
          if (pat_count != FULL)
            pat_count <= pat_count + 1'b1;
          if (pat_count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Seed reload happens on the launch edge, so the first RUN cycle already
  // presents LFSR_SEED[5:0].
  assign pat_o = running ? lfsr[PAT_W-1:0] : '0;

  bist_misr #(
    .W    (SIG_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (running),
    .din (resp_i),
    .sig (signature)
  );

`ifdef BIST_GOLDEN_CMP_EN
  assign pass = done && (signature == GOLDEN_SIG);
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN_SIG;
`endif

`ifndef SYNTHESIS
  a_seed_nonzero: assert property (@(posedge clk) disable iff (rst) LFSR_SEED != '0)
    else $error("LFSR_SEED must be non-zero");
`endif

endmodule

// File: tb/tb_lfsr_bist_wrapper.sv
module tb_lfsr_bist_wrapper;
  import bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st4, rs4, st2, rs2, st64, rs64;
  logic [5:0]  pat4, pat2, pat64;
  logic        busy4, busy2, busy64, done4, done2, done64;
  logic [15:0] sig4, sig2, sig64;
  logic [2:0]  cnt4;
  logic [1:0]  cnt2;
  logic [6:0]  cnt64;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  // Stand-in six-input layered circuit used as the golden-run load.
  function automatic logic layered(input logic [5:0] p);
    logic a, b, c, d, e, g, n1, n2, n3, n4;
    {a, b, c, d, e, g} = p;
    n1 = a & b;
    n2 = c ^ d;
    n3 = e | ~g;
    n4 = (n1 | n2) ^ (n3 & a);
    return n4 ^ (b & ~e);
  endfunction

  // Reference LFSR/MISR as plain integer arithmetic.
  function automatic int ref_lfsr(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  function automatic int ref_misr(input int s, input int r);
    int n;
    n = (s << 1) & 16'hFFFF;
    if (((s >> 15) & 1) != 0) n = n ^ 16'h1021;
    return n ^ (r & 1);
  endfunction

`ifdef BIST_GOLDEN_CMP_EN
  function automatic logic [15:0] golden_calc();
    int l, s;
    l = 16'hACE1;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      s = ref_misr(s, int'(layered(6'(l & 6'h3F))));
      l = ref_lfsr(l);
    end
    return 16'(s);
  endfunction
  localparam logic [15:0] GOLD = golden_calc();

  logic pass4, pass2, pass64, stg;
  logic [5:0]  patgp, patgf;
  logic        busygp, busygf, donegp, donegf, passgp, passgf;
  logic [15:0] siggp, siggf;
  logic [6:0]  cntgp, cntgf;

  lfsr_bist_wrapper #(.GOLDEN_SIG(GOLD)) dutgp (
    .clk(clk), .rst(rst), .start(stg), .resp_i(layered(patgp)), .pat_o(patgp),
    .busy(busygp), .done(donegp), .signature(siggp), .pat_count(cntgp), .pass(passgp));
  lfsr_bist_wrapper #(.GOLDEN_SIG(GOLD ^ 16'h0001)) dutgf (
    .clk(clk), .rst(rst), .start(stg), .resp_i(layered(patgf)), .pat_o(patgf),
    .busy(busygf), .done(donegf), .signature(siggf), .pat_count(cntgf), .pass(passgf));
`endif

  lfsr_bist_wrapper #(.N_PATTERNS(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .resp_i(rs4), .pat_o(pat4),
    .busy(busy4), .done(done4), .signature(sig4), .pat_count(cnt4)
`ifdef BIST_GOLDEN_CMP_EN
    , .pass(pass4)
`endif
  );
  lfsr_bist_wrapper #(.N_PATTERNS(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .resp_i(rs2), .pat_o(pat2),
    .busy(busy2), .done(done2), .signature(sig2), .pat_count(cnt2)
`ifdef BIST_GOLDEN_CMP_EN
    , .pass(pass2)
`endif
  );
  lfsr_bist_wrapper dut64 (
    .clk(clk), .rst(rst), .start(st64), .resp_i(rs64), .pat_o(pat64),
    .busy(busy64), .done(done64), .signature(sig64), .pat_count(cnt64)
`ifdef BIST_GOLDEN_CMP_EN
    , .pass(pass64)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        resp;
    logic [5:0]  pat;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int ml, ms, r;

    // Row = inputs held for one cycle, outputs observed in that cycle.
    tbl[0]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 16'h0000, 3'd0}; // IDLE, launch
    tbl[1]  = '{1'b0, 1'b0, 6'h21, 1'b1, 1'b0, 16'h0000, 3'd0}; // RUN 1
    tbl[2]  = '{1'b0, 1'b0, 6'h03, 1'b1, 1'b0, 16'h0000, 3'd1}; // RUN 2
    tbl[3]  = '{1'b0, 1'b0, 6'h07, 1'b1, 1'b0, 16'h0000, 3'd2};
    tbl[4]  = '{1'b1, 1'b0, 6'h0F, 1'b1, 1'b0, 16'h0000, 3'd3}; // start in RUN ignored
    tbl[5]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 16'h0000, 3'd4}; // DONE
    tbl[6]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 16'h0000, 3'd4}; // restart from DONE
    tbl[7]  = '{1'b0, 1'b1, 6'h21, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[8]  = '{1'b0, 1'b0, 6'h03, 1'b1, 1'b0, 16'h0001, 3'd1};
    tbl[9]  = '{1'b0, 1'b1, 6'h07, 1'b1, 1'b0, 16'h0002, 3'd2};
    tbl[10] = '{1'b0, 1'b1, 6'h0F, 1'b1, 1'b0, 16'h0005, 3'd3};
    tbl[11] = '{1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 16'h000B, 3'd4}; // DONE holds
    tbl[12] = '{1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 16'h000B, 3'd4};

    rst = 1'b1;
    st4 = 0; rs4 = 0; st2 = 0; rs2 = 0; st64 = 0; rs64 = 0;
`ifdef BIST_GOLDEN_CMP_EN
    stg = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.pat4",  pat4,  0);
    chk("rst.busy4", busy4, 0);
    chk("rst.done4", done4, 0);
    chk("rst.sig4",  sig4,  0);
    chk("rst.cnt4",  cnt4,  0);
    chk("rst.pat64", pat64, 0);
    chk("rst.sig64", sig64, 0);
    chk("rst.cnt64", cnt64, 0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("rst.pass64", pass64, 0);
`endif
    step();

    // Table-driven run / restart on the 4-pattern instance
    for (int i = 0; i < 13; i++) begin
      st4 = tbl[i].start;
      rs4 = tbl[i].resp;
      @(negedge clk);
      chk($sformatf("tbl%0d.pat", i),  pat4,  tbl[i].pat);
      chk($sformatf("tbl%0d.busy", i), busy4, tbl[i].busy);
      chk($sformatf("tbl%0d.done", i), done4, tbl[i].done);
      chk($sformatf("tbl%0d.sig", i),  sig4,  tbl[i].sig);
      chk($sformatf("tbl%0d.cnt", i),  cnt4,  tbl[i].cnt);
      step();
    end
    st4 = 0; rs4 = 0;

    // MISR with resp_i=1 on the 2-pattern instance
    st2 = 1; step();
    st2 = 0; rs2 = 1;
    @(negedge clk); chk("misr.busy1", busy2, 1);
    step();
    @(negedge clk); chk("misr.sig1", sig2, 16'h0001);
    step();
    rs2 = 0;
    @(negedge clk);
    chk("misr.done", done2, 1);
    chk("misr.sig2", sig2, 16'h0003);
    chk("misr.cnt",  cnt2, 2);
    step();

    // Reset in RUN cycle 2 discards the partial run
    st4 = 1; step();
    st4 = 0; rs4 = 1; step();
    @(negedge clk);
    chk("midrst.pat_before", pat4, 6'h03);
    chk("midrst.sig_before", sig4, 16'h0001);
    rst = 1; step();
    rst = 0; rs4 = 0;
    @(negedge clk);
    chk("midrst.pat",  pat4,  0);
    chk("midrst.busy", busy4, 0);
    chk("midrst.done", done4, 0);
    chk("midrst.sig",  sig4,  0);
    chk("midrst.cnt",  cnt4,  0);
    step();

    // Randomized runs on the default instance against the reference model
    for (int run = 0; run < 3; run++) begin
      r = int'($urandom_range(0, 3));
      for (int k = 0; k < r; k++) begin
        @(negedge clk);
        chk("rnd.idle_pat", pat64, 0);
        step();
      end
      st64 = 1; step();
      ml = 16'hACE1; ms = 0;
      for (int i = 0; i < 64; i++) begin
        st64 = (($urandom & 7) == 0);
        rs64 = $urandom & 1;
        @(negedge clk);
        chk($sformatf("rnd%0d.pat%0d", run, i), pat64, 32'(ml & 6'h3F));
        chk($sformatf("rnd%0d.cnt%0d", run, i), cnt64, i);
        chk("rnd.busy_done_excl", busy64 & done64, 0);
        ms = ref_misr(ms, int'(rs64));
        ml = ref_lfsr(ml);
        step();
      end
      st64 = 0; rs64 = $urandom & 1;
      repeat (2) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.done", run), done64, 1);
        chk($sformatf("rnd%0d.busy", run), busy64, 0);
        chk($sformatf("rnd%0d.sig", run),  sig64,  32'(ms));
        chk($sformatf("rnd%0d.cnt", run),  cnt64,  64);
        step();
      end
    end

`ifdef BIST_GOLDEN_CMP_EN
    // Golden compare: exact signature passes, one-bit-off golden fails
    stg = 1; step();
    stg = 0;
    @(negedge clk);
    chk("gold.pass_in_run", passgp, 0);
    repeat (64) step();
    @(negedge clk);
    chk("gold.done", donegp, 1);
    chk("gold.sig",  siggp,  GOLD);
    chk("gold.pass", passgp, 1);
    chk("gold.fail", passgf, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
